// File: rtl/regfile_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_arb_pkg
// Description : Shared types, defaults and helpers for the write-back arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_arb_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int AW_DEF      = 5;
  localparam int NUM_REQ_MAX = 8;

  typedef struct packed {
    logic [AW_DEF-1:0]   addr;
    logic [XLEN_DEF-1:0] data;
  } wb_req_t;

  // Index following idx in a ring of n entries.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : One-hot request arbiter. Round-robin from ptr when
//               WB_ARB_RR_EN is defined, otherwise fixed lowest-index priority.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
`ifdef WB_ARB_RR_EN
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
`endif
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int IW = $clog2(NUM_REQ);

  always_comb begin
    int   pos;
    logic found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef WB_ARB_RR_EN
      pos = (int'(ptr) + k) % NUM_REQ;
`else
      pos = k;
`endif
      if (!found && req[IW'(pos)]) begin
        found             = 1'b1;
        grant[IW'(pos)]   = 1'b1;
        idx               = IW'(pos);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Shares the register-file write port between NUM_REQ sources;
//               one accept per cycle into a registered write stage.
//               Config macro: WB_ARB_RR_EN (round-robin; else fixed priority).
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = XLEN_DEF,
  parameter int AW      = AW_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*AW-1:0]        req_addr,
  input  logic [NUM_REQ*XLEN-1:0]      req_data,
  output logic                         rf_we,
  output logic [AW-1:0]                rf_wa,
  output logic [XLEN-1:0]              rf_wd,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id
);

  localparam int IW = $clog2(NUM_REQ);

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } req_t;

  req_t              req_arr [NUM_REQ];
  req_t              sel;
  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] arb_grant;
  logic [IW-1:0]      arb_idx;
  logic               accept;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_arr[i] = {req_addr[i*AW +: AW], req_data[i*XLEN +: XLEN]};
  end

  // Masking requests during reset keeps ready low without touching the payload path.
  assign arb_req = rst ? '0 : req_valid;

`ifdef WB_ARB_RR_EN
  logic [IW-1:0] rr_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= IW'(rr_next(int'(arb_idx), NUM_REQ));
    end
  end
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req   (arb_req),
`ifdef WB_ARB_RR_EN
    .ptr   (rr_ptr),
`endif
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  assign req_ready = arb_grant;
  assign accept    = |arb_grant;
  assign sel       = req_arr[arb_idx];

  // x0 writes are consumed but never raise the write enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_wa    <= '0;
      rf_wd    <= '0;
      grant_id <= '0;
    end else if (accept) begin
      rf_we    <= |sel.addr;
      rf_wa    <= sel.addr;
      rf_wd    <= sel.data;
      grant_id <= arb_idx;
    end else begin
      rf_we    <= 1'b0;
    end
  end

endmodule
`default_nettype wire
